// File: rtl/hazard_scoreboard_ctrl.sv
// Stall/flush controller for a non-forwarding 5-stage RV32I pipeline using per-register countdown scoreboard.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_scoreboard_ctrl #(
    parameter int PEND_CYC = 2,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_redirect,
    output logic        stall,
    output logic        flush_ifid,
    output logic        bubble_idex,
    output logic [31:0] busy_map
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    logic [CNT_W-1:0] cnt_q [0:31];
    logic [CNT_W-1:0] cnt_d [0:31];
    logic [6:0]       opcode_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic [4:0]       rd_s;
    logic             uses_rs1_s;
    logic             uses_rs2_s;
    logic             writes_rd_s;
    logic             haz_s;
    logic             issue_s;
    logic             unused_instr_s;

    assign opcode_s       = id_instr[6:0];
    assign rs1_s          = id_instr[19:15];
    assign rs2_s          = id_instr[24:20];
    assign rd_s           = id_instr[11:7];
    assign unused_instr_s = ^{id_instr[31:25], id_instr[14:12]};

    // Opcode decode: which register fields the ID instruction reads and writes
    always_comb begin
        uses_rs1_s  = 1'b0;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        case (opcode_s)
            7'b0110011: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; writes_rd_s = 1'b1; end
            7'b0010011: begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
            7'b0000011: begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
            7'b0100011: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            7'b1100011: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            7'b1100111: begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
            7'b1101111: writes_rd_s = 1'b1;
            7'b0110111: writes_rd_s = 1'b1;
            7'b0010111: writes_rd_s = 1'b1;
            default: begin
                uses_rs1_s  = 1'b0;
                uses_rs2_s  = 1'b0;
                writes_rd_s = 1'b0;
            end
        endcase
    end

    // RAW hazard detection and pipeline control outputs
    always_comb begin
        haz_s = id_valid &
                ((uses_rs1_s & (rs1_s != 5'd0) & (cnt_q[rs1_s] != {CNT_W{1'b0}})) |
                 (uses_rs2_s & (rs2_s != 5'd0) & (cnt_q[rs2_s] != {CNT_W{1'b0}})));
        issue_s     = id_valid & ~haz_s & ~ex_redirect;
        stall       = haz_s & ~ex_redirect;
        flush_ifid  = ex_redirect;
        bubble_idex = (haz_s & ~ex_redirect) | ex_redirect;
    end

    // Scoreboard next state: reload on issue wins over the running decrement
    always_comb begin
        cnt_d[0] = {CNT_W{1'b0}};
        for (int i = 1; i < 32; i++) begin
            if (issue_s && writes_rd_s && (rd_s == 5'(i))) begin
                cnt_d[i] = CNT_W'(PEND_CYC);
            end else if (cnt_q[i] != {CNT_W{1'b0}}) begin
                cnt_d[i] = cnt_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Debug view of pending destination registers
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy_map[i] = (cnt_q[i] != {CNT_W{1'b0}});
        end
    end

    // Scoreboard counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Stall-cycle and redirect event counters, frozen while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, stall};
            perf_flush_q <= perf_flush_q + {31'd0, ex_redirect};
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Self-checking bench for hazard_scoreboard_ctrl: directed vector table plus randomized traffic vs a cycle-stamp model.
module tb_hazard_scoreboard_ctrl;

    localparam int PEND_CYC = 2;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_redirect;
    logic        stall;
    logic        flush_ifid;
    logic        bubble_idex;
    logic [31:0] busy_map;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    hazard_scoreboard_ctrl #(.PEND_CYC(PEND_CYC), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .bubble_idex (bubble_idex),
        .busy_map    (busy_map)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        red;
        logic        r;
        logic        e_stall;
        logic        e_flush;
        logic        e_bub;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    localparam logic [31:0] ADDI_X5   = 32'h00100293;
    localparam logic [31:0] ADD_655   = 32'h00528333;
    localparam logic [31:0] ADD_650   = 32'h00028333;
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ADDI_X7   = 32'h00100393;
    localparam logic [31:0] LUI_X7    = 32'h123453B7;
    localparam logic [31:0] ADDI_X0   = 32'h00500013;
    localparam logic [31:0] ADDI_X8   = 32'h00300413;
    localparam logic [31:0] SW_X5_X6  = 32'h00532023;
    localparam logic [31:0] ADDI_X5X5 = 32'h00228293;
    localparam logic [31:0] B5 = 32'h00000020;
    localparam logic [31:0] B6 = 32'h00000040;
    localparam logic [31:0] B7 = 32'h00000080;
    localparam logic [31:0] B8 = 32'h00000100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic av(input logic v, input logic [31:0] ins, input logic red, input logic r,
                      input logic es, input logic [31:0] eb);
        vec_t t;
        t.v = v; t.ins = ins; t.red = red; t.r = r;
        t.e_stall = es; t.e_flush = red; t.e_bub = es | red; t.e_busy = eb;
        vecs.push_back(t);
    endtask

    // reference model: cycle at which each register's producer reaches WB
    longint wb_cyc [0:31];
    longint cyc;
    int     m_stall_cnt;
    int     m_flush_cnt;

    function automatic void dec(input logic [31:0] ins, output logic u1, output logic u2, output logic w);
        u1 = 1'b0; u2 = 1'b0; w = 1'b0;
        case (ins[6:0])
            7'b0110011: begin u1 = 1'b1; u2 = 1'b1; w = 1'b1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin u1 = 1'b1; w = 1'b1; end
            7'b0100011, 7'b1100011: begin u1 = 1'b1; u2 = 1'b1; end
            7'b1101111, 7'b0110111, 7'b0010111: w = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic logic pend(input int r);
        return (r != 0) && (cyc < wb_cyc[r]);
    endfunction

    function automatic logic m_haz(input logic v, input logic [31:0] ins);
        logic u1, u2, w;
        dec(ins, u1, u2, w);
        return v && ((u1 && pend(int'(ins[19:15]))) || (u2 && pend(int'(ins[24:20]))));
    endfunction

    initial begin
        logic [6:0] ops [0:9];
        logic [31:0] ins, eb;
        logic v, red, r, hz, st, u1, u2, w;
        n_checks = 0;
        n_fail = 0;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1100111; ops[6] = 7'b1101111; ops[7] = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b1110011;

        // back-to-back RAW
        av(1, ADDI_X5, 0, 0, 0, 32'd0);
        av(1, ADD_655, 0, 0, 1, B5);
        av(1, ADD_655, 0, 0, 1, B5);
        av(1, ADD_655, 0, 0, 0, 32'd0);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, 32'd0);
        // distance 2
        av(1, ADDI_X5, 0, 0, 0, 32'd0);
        av(1, NOP, 0, 0, 0, B5);
        av(1, ADD_650, 0, 0, 1, B5);
        av(1, ADD_650, 0, 0, 0, 32'd0);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, B6);
        // distance 3
        av(1, ADDI_X5, 0, 0, 0, 32'd0);
        av(1, NOP, 0, 0, 0, B5);
        av(1, NOP, 0, 0, 0, B5);
        av(1, ADD_650, 0, 0, 0, 32'd0);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, 32'd0);
        // ignored operands and x0 writes
        av(1, ADDI_X7, 0, 0, 0, 32'd0);
        av(1, LUI_X7, 0, 0, 0, B7);
        av(0, NOP, 0, 0, 0, B7);
        av(0, NOP, 0, 0, 0, B7);
        av(1, ADDI_X0, 0, 0, 0, 32'd0);
        av(1, ADDI_X8, 0, 0, 0, 32'd0);
        av(0, NOP, 0, 0, 0, B8);
        av(0, NOP, 0, 0, 0, B8);
        // flush beats stall; squashed rd not loaded
        av(1, ADDI_X5, 0, 0, 0, 32'd0);
        av(1, SW_X5_X6, 1, 0, 0, B5);
        av(1, ADD_655, 1, 0, 0, B5);
        av(0, NOP, 0, 0, 0, 32'd0);
        // reload beats decrement
        av(1, ADDI_X5, 0, 0, 0, 32'd0);
        av(1, ADDI_X5X5, 0, 0, 1, B5);
        av(1, ADDI_X5X5, 0, 0, 1, B5);
        av(1, ADDI_X5X5, 0, 0, 0, 32'd0);
        av(1, ADDI_X5, 0, 0, 0, B5);
        av(0, NOP, 0, 0, 0, B5);
        av(0, NOP, 0, 0, 0, B5);
        av(0, NOP, 0, 0, 0, 32'd0);
        // reset mid-stall
        av(1, ADDI_X5, 0, 0, 0, 32'd0);
        av(1, ADD_655, 0, 1, 1, B5);
        av(1, ADD_655, 0, 0, 0, 32'd0);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, B6);
        av(0, NOP, 0, 0, 0, 32'd0);
        // redirect with a bubble in ID
        av(0, NOP, 1, 0, 0, 32'd0);

        rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_flush", {31'd0, flush_ifid}, 32'd0);
        chk("reset_bubble", {31'd0, bubble_idex}, 32'd0);
        chk("reset_busy", busy_map, 32'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("reset_perf_stall", perf_stall_cyc, 32'd0);
        chk("reset_perf_flush", perf_flush_cnt, 32'd0);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            id_valid = vecs[k].v; id_instr = vecs[k].ins;
            ex_redirect = vecs[k].red; rst = vecs[k].r;
            #1;
            chk($sformatf("vec%0d_stall", k), {31'd0, stall}, {31'd0, vecs[k].e_stall});
            chk($sformatf("vec%0d_flush", k), {31'd0, flush_ifid}, {31'd0, vecs[k].e_flush});
            chk($sformatf("vec%0d_bubble", k), {31'd0, bubble_idex}, {31'd0, vecs[k].e_bub});
            chk($sformatf("vec%0d_busy", k), busy_map, vecs[k].e_busy);
        end

        // randomized phase, starting from a fresh reset
        @(negedge clk);
        rst = 1'b1; id_valid = 1'b0; ex_redirect = 1'b0;
        @(posedge clk);
        cyc = 1; m_stall_cnt = 0; m_flush_cnt = 0;
        for (int i = 0; i < 32; i++) wb_cyc[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            v   = ($urandom_range(3) != 0);
            red = ($urandom_range(7) == 0);
            r   = ($urandom_range(63) == 0);
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(9)];
            ins[11:7]  = 5'($urandom_range(7));
            ins[19:15] = 5'($urandom_range(7));
            ins[24:20] = 5'($urandom_range(7));
            id_valid = v; id_instr = ins; ex_redirect = red; rst = r;
            #1;
            hz = m_haz(v, ins);
            st = hz && !red;
            eb = 32'd0;
            for (int i = 1; i < 32; i++) eb[i] = pend(i);
            chk("rnd_stall", {31'd0, stall}, {31'd0, st});
            chk("rnd_flush", {31'd0, flush_ifid}, {31'd0, red});
            chk("rnd_bubble", {31'd0, bubble_idex}, {31'd0, st | red});
            chk("rnd_busy", busy_map, eb);
`ifdef HAZ_PERF_CNT_EN
            chk("rnd_perf_stall", perf_stall_cyc, 32'(m_stall_cnt));
            chk("rnd_perf_flush", perf_flush_cnt, 32'(m_flush_cnt));
`endif
            @(posedge clk);
            if (r) begin
                for (int i = 0; i < 32; i++) wb_cyc[i] = 0;
                m_stall_cnt = 0;
                m_flush_cnt = 0;
            end else begin
                dec(ins, u1, u2, w);
                if (v && !hz && !red && w && ins[11:7] != 5'd0)
                    wb_cyc[ins[11:7]] = cyc + 1 + PEND_CYC;
                m_stall_cnt += int'(st);
                m_flush_cnt += int'(red);
            end
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Stall/flush controller for the non-forwarding 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Decodes the instruction in ID and tracks in-flight destination registers with per-register countdown counters.
- Stalls ID on a RAW hazard until the producer reaches WB. The register file is write-first.
- Kills the wrong-path instructions when EX resolves a taken branch or jump.

Parameters:
- PEND_CYC, 2, value loaded into a register's counter on issue; cycles until the producer is in WB.
- CNT_W, 2, counter width; must satisfy 2^CNT_W > PEND_CYC.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_instr  in  32  instruction in ID
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR this cycle
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  clear IF/ID at next edge
- bubble_idex  out  1  load NOP into ID/EX at next edge
- busy_map  out  32  bit i = counter[i] != 0 (debug)

Behaviour:
- **Decode** of id_instr[6:0]; rs1=[19:15], rs2=[24:20], rd=[11:7].
  - uses_rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2: 0110011, 0100011, 1100011.
  - writes_rd: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode uses and writes nothing and never stalls.
- **Scoreboard**: cnt[1..31], each CNT_W bits. x0 is never pending (reads as 0, writes ignored).
- **Hazard (combinational, same cycle)**:
  - haz = id_valid & ((uses_rs1 & rs1!=0 & cnt[rs1]!=0) | (uses_rs2 & rs2!=0 & cnt[rs2]!=0)).
- **Outputs (combinational)**:
  - stall = haz & ~ex_redirect.
  - flush_ifid = ex_redirect.
  - bubble_idex = stall | ex_redirect.
- **Issue**: issue = id_valid & ~haz & ~ex_redirect.
- **Per-register update at each clk edge**, first match wins:
  - rst: cnt := 0.
  - issue & writes_rd & rd==i & i!=0: cnt[i] := PEND_CYC. A reload beats a decrement of the same register.
  - cnt[i]!=0: cnt[i] := cnt[i]-1. Counters decrement every cycle regardless of stall, because EX/MEM/WB keep moving.
- **Timing**, producer issued at edge t with PEND_CYC=2:
  - cnt=2 in cycle t+1 (EX) and 1 in t+2 (MEM); dependent instruction stalls.
  - cnt=0 in t+3 (WB); dependent instruction issues and reads the written value (write-first).
  - Maximum stall is 2 cycles for back-to-back dependence.
- **Redirect**:
  - The instruction in ID is squashed: no scoreboard load, 1 bubble into EX.
  - IF/ID is cleared, giving 2 bubbles total.
  - Redirect with haz in the same cycle: flush wins, stall=0.
- **Bubble in ID** (id_valid=0): never stalls, never loads.
- **Reset mid-operation**: all counters cleared at the next edge; outputs follow the cleared state.
  - During rst the outputs are still computed from the current state and inputs. The pipeline is itself in reset.
- After reset: stall=0, flush_ifid=0, bubble_idex=0, busy_map=0 (given id_valid=0, ex_redirect=0).

Optional Feature:
- **HAZ_PERF_CNT_EN defined**:
  - Adds outputs perf_stall_cyc[31:0] (increments each cycle stall=1) and perf_flush_cnt[31:0] (increments each cycle ex_redirect=1).
  - Both are cleared by rst and wrap at 2^32.
  - The increment is suppressed in a cycle where rst=1.
- **Macro undefined**: ports and counters are absent; all other behaviour is identical.

Test Plan:
- **Back-to-back RAW**: issue addi x5,x0,1 (0x00100293), then add x6,x5,x5 in ID -> stall=1, bubble_idex=1 for 2 cycles, busy_map[5]=1 then 0; add issues in the 3rd cycle.
- **Distance-2 dependence**: addi x5, nop, add x6,x5,x0 -> 1 stall cycle. Distance 3 -> 0 stalls.
- **Ignored operands**: lui x7,0x12345 with x7 pending -> no stall (lui uses no rs). addi x8,x0,3 with x0 write attempted earlier -> busy_map[0]=0 and no stall.
- **Flush beats stall**: ex_redirect=1 in the same cycle as a hazard on sw x5,0(x6) -> stall=0, flush_ifid=1, bubble_idex=1, and the squashed instruction's rd is not loaded.
- **Reload beats decrement**: addi x5,x0,1, then the next cycle addi x5,x5,2 after the stall clears, while cnt[5] is still decrementing -> cnt[5]=2 reloaded. Assert rst mid-stall -> busy_map=0 and stall=0 at the next cycle.
- **Perf counters** (HAZ_PERF_CNT_EN defined): the sequence above -> perf_stall_cyc equals the number of stall cycles (e.g. 2) and perf_flush_cnt=1; both read 0 after rst.
